map_bram_arbiter: RTL

Round-robin arbiter that shares the single-port map BROM between NUM_REQ parallel DDA stepping engines. It accepts one address per requester per outstanding read and issues at most one BROM read per cycle. It tags each in-flight read with its requester index, then returns the 4-bit map cell to that requester with a single-cycle valid pulse. It sits between the DDA engine bank and the map BROM, in the pixel clock domain.

---
 rtl/map_bram_arbiter_if.sv | 24 ++
 rtl/map_bram_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/map_bram_arbiter_if.sv
// Bus bundle between the DDA engine bank, the map BROM and map_bram_arbiter.
// The master side is the engine bank together with the BROM; the slave side is the arbiter.
interface map_bram_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10
);
  logic [NUM_REQ-1:0]        req_in;
  logic [NUM_REQ*ADDR_W-1:0] addr_in;
  logic [ADDR_W-1:0]         bram_addra_out;
  logic [3:0]                bram_data_in;
  logic [3:0]                data_out;
  logic [NUM_REQ-1:0]        valid_out;
  logic                      busy_out;

  modport master (
    output req_in, addr_in, bram_data_in,
    input  bram_addra_out, data_out, valid_out, busy_out
  );

  modport slave (
    input  req_in, addr_in, bram_data_in,
    output bram_addra_out, data_out, valid_out, busy_out
  );
endinterface

// File: rtl/map_bram_arbiter.sv
// Round-robin sharing of the single-port map BROM between NUM_REQ DDA engines.
// Each in-flight read is tagged with its requester and returned as a one-hot valid pulse.
module map_bram_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int N            = 24,
  parameter int ADDR_W       = $clog2(N*N),
  parameter int BRAM_LATENCY = 2
) (
  input  logic              pixel_clk_in,
  input  logic              rst_in,
  map_bram_arbiter_if.slave bus
);
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int STAGES = BRAM_LATENCY + 1;
  localparam logic [ADDR_W:0]    CELLS = (ADDR_W+1)'(N*N);
  localparam logic [NUM_REQ-1:0] ONE   = NUM_REQ'(1);

  logic [IDX_W-1:0]   ptr;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] eligible;
  logic               grant_valid;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   next_ptr;
  logic [ADDR_W-1:0]  grant_addr;
  logic               grant_oob;

  logic [STAGES-1:0]  tag_valid;
  logic [STAGES-1:0]  tag_oob;
  logic [IDX_W-1:0]   tag_idx [STAGES];

  logic [ADDR_W-1:0]  addra_q;
  logic [3:0]         data_q;
  logic [NUM_REQ-1:0] valid_q;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // An engine whose read is still in flight (including its return cycle) is never re-granted.
  always_comb eligible = bus.req_in & ~pending;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!grant_valid && eligible[wrap_add(ptr, off)]) begin
        grant_valid = 1'b1;
        grant_idx   = wrap_add(ptr, off);
      end
    end
  end

  always_comb begin
    next_ptr   = (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
    grant_addr = bus.addr_in[grant_idx*ADDR_W +: ADDR_W];
    grant_oob  = ({1'b0, grant_addr} >= CELLS);
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      ptr     <= '0;
      addra_q <= '0;
      pending <= '0;
    end else begin
      pending <= (pending & ~valid_q) | (grant_valid ? (ONE << grant_idx) : '0);
      if (grant_valid) begin
        ptr     <= next_ptr;
        addra_q <= grant_addr;
      end
    end
  end

  // Tags travel alongside the BROM read so the return lines up with bram_data_in.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      tag_valid <= '0;
      tag_oob   <= '0;
      for (int k = 0; k < STAGES; k++) tag_idx[k] <= '0;
    end else begin
      tag_valid <= {tag_valid[STAGES-2:0], grant_valid};
      tag_oob   <= {tag_oob[STAGES-2:0], grant_oob};
      tag_idx[0] <= grant_idx;
      for (int k = 1; k < STAGES; k++) tag_idx[k] <= tag_idx[k-1];
    end
  end

  // Out-of-map reads come back as wall so a ray leaving the map terminates.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      data_q  <= '0;
      valid_q <= '0;
    end else if (tag_valid[STAGES-1]) begin
      data_q  <= tag_oob[STAGES-1] ? 4'd1 : bus.bram_data_in;
      valid_q <= ONE << tag_idx[STAGES-1];
    end else begin
      valid_q <= '0;
    end
  end

  assign bus.bram_addra_out = addra_q;
  assign bus.data_out       = data_q;
  assign bus.valid_out      = valid_q;
  assign bus.busy_out       = |pending;
endmodule
